// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_BLANK = 4'b1111;
endpackage

// File: rtl/dabble_nibble.sv
// One BCD digit correction step: add 3 when the nibble is 5 or more.
module dabble_nibble (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter with busy/done handshake.
// Define OVERFLOW_DETECT_EN to blank all digits and raise ovf on out-of-range input.
module bin_to_bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);
  localparam int SW = DIGIT_W * (DIGITS + 1);
  localparam int CW = $clog2(BIN_W + 1);

  conv_state_t      r_state;
  conv_state_t      w_next;
  logic [BIN_W-1:0] r_shreg;
  logic [SW-1:0]    r_scr;
  logic [CW-1:0]    r_cnt;
  logic [4*DIGITS-1:0] r_bcd;
  logic             r_ovf;
  logic [SW-1:0]    w_adj;
  logic [SW-1:0]    w_scr_nxt;
  logic             w_accept;
  logic             w_last;

  for (genvar g = 0; g <= DIGITS; g++) begin : g_dab
    dabble_nibble u_dab (
      .i_nib (r_scr[g*DIGIT_W +: DIGIT_W]),
      .o_nib (w_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign w_scr_nxt = {w_adj[SW-2:0], r_shreg[BIN_W-1]};
  assign w_accept  = (r_state != SHIFT) && start;
  assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_shreg <= bin;
        r_scr   <= '0;
        r_cnt   <= CW'(BIN_W);
      end else if (r_state == SHIFT) begin
        r_scr   <= w_scr_nxt;
        r_shreg <= {r_shreg[BIN_W-2:0], 1'b0};
        r_cnt   <= r_cnt - CW'(1);
      end
      if (w_last) begin
`ifdef OVERFLOW_DETECT_EN
        r_ovf <= (w_scr_nxt[SW-1 -: DIGIT_W] != '0);
        r_bcd <= (w_scr_nxt[SW-1 -: DIGIT_W] != '0)
               ? {DIGITS{BCD_BLANK}}
               : w_scr_nxt[4*DIGITS-1:0];
`else
        r_ovf <= 1'b0;
        r_bcd <= w_scr_nxt[4*DIGITS-1:0];
`endif
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter (BIN_W=10, DIGITS=3).
module tb_bin_to_bcd_converter;
  localparam int BIN_W = 10;
  localparam int DIGITS = 3;

  logic        clk = 0;
  logic        rst;
  logic        start;
  logic [9:0]  bin;
  logic        busy, done, ovf;
  logic [11:0] bcd;

  int n_pass = 0;
  int n_tot  = 0;

  bin_to_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  b;
    logic [11:0] e_bcd;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [12:0] ref_model(input int v);
    int d;
    logic [11:0] r;
    logic o;
    d = v % 1000;
    r = {4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
    o = 1'b0;
`ifdef OVERFLOW_DETECT_EN
    if (v > 999) begin
      o = 1'b1;
      r = 12'hFFF;
    end
`endif
    return {o, r};
  endfunction

  task automatic wait_idle();
    int k = 0;
    while ((busy || done) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'd0, busy | done}, 32'd0);
  endtask

  task automatic convert(input logic [9:0] v, input logic [11:0] eb,
                         input logic eo, input string nm);
    int nb;
    wait_idle();
    start = 1;
    bin = v;
    @(negedge clk);
    start = 0;
    bin = 10'($urandom);
    nb = 0;
    while (!done && nb < 40) begin
      if (busy) nb++;
      @(negedge clk);
    end
    chk({nm, "_lat"}, nb, BIN_W);
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_bcd"}, {20'd0, bcd}, {20'd0, eb});
    chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    @(negedge clk);
    chk({nm, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [12:0] m;
    int ndone, last_t, t;
    tbl[0] = '{10'd0,   12'h000, 1'b0};
    tbl[1] = '{10'd999, 12'h999, 1'b0};
    tbl[2] = '{10'd537, 12'h537, 1'b0};
`ifdef OVERFLOW_DETECT_EN
    tbl[3] = '{10'd1023, 12'hFFF, 1'b1};
`else
    tbl[3] = '{10'd1023, 12'h023, 1'b0};
`endif
    tbl[4] = '{10'd1,   12'h001, 1'b0};
    tbl[5] = '{10'd9,   12'h009, 1'b0};
    tbl[6] = '{10'd10,  12'h010, 1'b0};
    tbl[7] = '{10'd500, 12'h500, 1'b0};
    tbl[8] = '{10'd88,  12'h088, 1'b0};

    rst = 1; start = 0; bin = 0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bcd", {20'd0, bcd}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      convert(tbl[i].b, tbl[i].e_bcd, tbl[i].e_ovf, $sformatf("tbl%0d", i));

    for (int i = 0; i < 20; i++) begin
      int v;
      v = int'($urandom_range(0, 1023));
      m = ref_model(v);
      convert(10'(v), m[11:0], m[12], $sformatf("rnd%0d", v));
    end

    // start pulses while busy must be ignored
    wait_idle();
    start = 1; bin = 10'd100;
    @(negedge clk);
    start = 0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 2 || c == 4 || c == 6) begin
        start = 1; bin = 10'd5;
      end else begin
        start = 0;
      end
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("ign_bcd", {20'd0, bcd}, 32'h100);
      end
    end
    chk("ign_count", ndone, 1);

    // start held high: back-to-back conversions
    wait_idle();
    start = 1; bin = 10'd42;
    ndone = 0; last_t = -1;
    for (t = 0; t < 60; t++) begin
      @(negedge clk);
      if (done) begin
        chk("hold_bcd", {20'd0, bcd}, 32'h042);
        if (last_t >= 0) chk("hold_gap", t - last_t, BIN_W + 1);
        last_t = t;
        ndone++;
      end
    end
    start = 0;
    chk("hold_count_ok", {31'd0, ndone >= 4}, 32'd1);
    wait_idle();

    // reset mid-conversion
    start = 1; bin = 10'd777;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_bcd", {20'd0, bcd}, 32'd0);
    chk("mid_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid_nodone", ndone, 0);
    convert(10'd321, 12'h321, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
